// File: rtl/expm1_pkg.sv
// ============================================================================
// Module      : expm1_pkg
// Description : Formats, state encoding and reciprocal table for expm1_series.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package expm1_pkg;

  localparam int Y_W = 18;
  localparam int Y_F = 16;
  localparam int T_W = 30;
  localparam int T_F = 24;
  localparam int E_W = 22;
  localparam int E_F = 16;
  localparam int R_F = 18;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL_Y = 2'd1,
    S_MUL_R = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // round(2^18 / n) in Q0.18; indices outside 2..31 never reach the datapath
  function automatic logic [R_F-1:0] recip(input logic [4:0] n);
    logic [R_F-1:0] r;
    case (n)
      5'd2:    r = 18'd131072;
      5'd3:    r = 18'd87381;
      5'd4:    r = 18'd65536;
      5'd5:    r = 18'd52429;
      5'd6:    r = 18'd43691;
      5'd7:    r = 18'd37449;
      5'd8:    r = 18'd32768;
      5'd9:    r = 18'd29127;
      5'd10:   r = 18'd26214;
      5'd11:   r = 18'd23831;
      5'd12:   r = 18'd21845;
      5'd13:   r = 18'd20165;
      5'd14:   r = 18'd18725;
      5'd15:   r = 18'd17476;
      5'd16:   r = 18'd16384;
      5'd17:   r = 18'd15420;
      5'd18:   r = 18'd14564;
      5'd19:   r = 18'd13797;
      5'd20:   r = 18'd13107;
      5'd21:   r = 18'd12483;
      5'd22:   r = 18'd11916;
      5'd23:   r = 18'd11398;
      5'd24:   r = 18'd10923;
      5'd25:   r = 18'd10486;
      5'd26:   r = 18'd10082;
      5'd27:   r = 18'd9709;
      5'd28:   r = 18'd9362;
      5'd29:   r = 18'd9039;
      5'd30:   r = 18'd8738;
      5'd31:   r = 18'd8456;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/expm1_term_mul.sv
// ============================================================================
// Module      : expm1_term_mul
// Description : Shared 30x18 multiplier with selectable right shift (16/18),
//               combinational result plus a registered copy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expm1_term_mul
  import expm1_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [T_W-1:0] a_i,
  input  logic [Y_W-1:0] b_i,
  input  logic           shr18_i,
  input  logic           load_i,
  output logic [T_W-1:0] p_o,
  output logic [T_W-1:0] prod_o
);

  localparam int P_W = T_W + Y_W;

  logic [T_W-1:0] prod_q;

  always_comb begin
    if (shr18_i) p_o = T_W'((P_W'(a_i) * P_W'(b_i)) >> R_F);
    else         p_o = T_W'((P_W'(a_i) * P_W'(b_i)) >> Y_F);
  end

  always_ff @(posedge clk) begin
    if (rst)         prod_q <= '0;
    else if (load_i) prod_q <= p_o;
  end

  assign prod_o = prod_q;

endmodule

`default_nettype wire

// File: rtl/expm1_series.sv
// ============================================================================
// Module      : expm1_series
// Description : Iterative Maclaurin evaluator of e^y - 1, two cycles per term.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expm1_series
  import expm1_pkg::*;
#(
  parameter int N_TERMS = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Y_W-1:0] yBus,
  output logic [E_W-1:0] eBus,
  output logic           done
);

  state_e         state_q, state_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [T_W-1:0] term_q, term_d;
  logic [T_W-1:0] acc_q, acc_d;
  logic [4:0]     n_q, n_d;

  logic [T_W-1:0] w_mul_a;
  logic [Y_W-1:0] w_mul_b;
  logic           w_shr18;
  logic           w_load;
  logic [T_W-1:0] w_t;
  logic [T_W-1:0] w_prod;

  // MUL_Y forms term*y into the product register; MUL_R scales it by 1/n
  assign w_shr18 = (state_q == S_MUL_R);
  assign w_load  = (state_q == S_MUL_Y);
  assign w_mul_a = w_shr18 ? w_prod : term_q;
  assign w_mul_b = w_shr18 ? recip(n_q) : y_q;

  expm1_term_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .a_i     (w_mul_a),
    .b_i     (w_mul_b),
    .shr18_i (w_shr18),
    .load_i  (w_load),
    .p_o     (w_t),
    .prod_o  (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      n_q     <= 5'd2;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    term_d  = term_q;
    acc_d   = acc_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          y_d     = yBus;
          term_d  = {4'b0, yBus, 8'b0};
          acc_d   = {4'b0, yBus, 8'b0};
          n_d     = 5'd2;
          state_d = S_MUL_Y;
        end
      end
      S_MUL_Y: state_d = S_MUL_R;
      S_MUL_R: begin
        term_d = w_t;
        acc_d  = acc_q + w_t;
        n_d    = n_q + 5'd1;
        if ((n_q == 5'(N_TERMS)) || (w_t == '0)) state_d = S_DONE;
        else                                     state_d = S_MUL_Y;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done = (state_q == S_DONE);
  assign eBus = done ? acc_q[T_W-1:T_F-E_F] : '0;

endmodule

`default_nettype wire

// File: tb/tb_expm1_series.sv
// ============================================================================
// Module      : tb_expm1_series
// Description : Directed self-checking bench for expm1_series.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_expm1_series;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [17:0] yBus;
  logic [21:0] eBus;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int cnt;

  always #5 clk = ~clk;

  expm1_series #(.N_TERMS(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .yBus  (yBus),
    .eBus  (eBus),
    .done  (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int d;
    checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    assert ((d <= tol) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h tol=%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic launch(input logic [17:0] y);
    yBus  = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; yBus = '0;
    tick(); tick();
    chk("reset_done", int'(done), 0, 0);
    chk("reset_ebus", int'(eBus), 0, 0);
    rst = 1'b0;

    // y = 0 terminates after one term
    launch(18'h00000);
    wait_done(cyc);
    chk("zero_latency", cyc, 2, 0);
    chk("zero_ebus", int'(eBus), 0, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1 && eBus === 22'h0) cnt++;
    end
    chk("zero_hold", cnt, 30, 0);

    launch(18'h01E27);
    wait_done(cyc);
    chk("ln1p125_done", int'(done), 1, 0);
    chk("ln1p125_ebus", int'(eBus), 32'h002000, 2);

    launch(18'h0B172);
    wait_done(cyc);
    chk("ln2_ebus", int'(eBus), 32'h010000, 2);

    launch(18'h162E4);
    wait_done(cyc);
    chk("ln4_ebus", int'(eBus), 32'h030000, 4);

    launch(18'h3FFFF);
    wait_done(cyc);
    chk("max_latency", cyc, 38, 0);
    chk("max_ebus", int'(eBus), 32'h3598EB, 8);

    // start re-pulsed mid-computation must be ignored
    launch(18'h3FFFF);
    repeat (9) tick();
    yBus  = 18'h0B172;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    chk("busy_latency", cyc + 10, 38, 0);
    chk("busy_ebus", int'(eBus), 32'h3598EB, 8);

    // reset mid-computation discards the result
    launch(18'h3FFFF);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    chk("midrst_done", int'(done), 0, 0);
    chk("midrst_ebus", int'(eBus), 0, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done !== 1'b0) cnt++;
    end
    chk("midrst_idle", cnt, 0, 0);

    // start held high: done high after edges 2,5,8,11
    yBus  = 18'h00000;
    start = 1'b1;
    tick();
    cnt = 0;
    if (done !== 1'b0) cnt++;
    for (int k = 1; k < 12; k++) begin
      tick();
      if (done !== ((k % 3) == 2)) cnt++;
    end
    start = 1'b0;
    chk("b2b_pattern", cnt, 0, 0);
    chk("b2b_ebus", int'(eBus), 0, 0);

    // rst and start together: nothing is accepted
    rst   = 1'b1;
    start = 1'b1;
    yBus  = 18'h3FFFF;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rststart_done", int'(done), 0, 0);
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done !== 1'b0) cnt++;
    end
    chk("rststart_idle", cnt, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
